// File: rtl/mc_control_fsm_if.sv
// Control-unit boundary of the multicycle core: decode inputs from the IR and ALU,
// and every datapath enable/select driven back into the datapath.
interface mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       irwrite;
  logic       memwrite;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       halt;
  logic [3:0] state_dbg;

  modport master (
    output op, funct, zero,
    input  irwrite, memwrite, iord, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, halt, state_dbg
  );

  modport slave (
    input  op, funct, zero,
    output irwrite, memwrite, iord, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, halt, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM + ALU decoder for the multicycle MIPS core; lw 5, sw/R/addi 4, beq/j 3 cycles.
// No backpressure: memory is synchronous, one state per clock; async reset forces all enables low.
module mc_control_fsm #(
  parameter bit TRAP_ILLEGAL = 1'b0
) (
  input logic           clk,
  input logic           reset_n,
  mc_control_fsm_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQEX  = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JEX    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t     state, next_state;
  logic       is_sw;
  logic       pcwrite, branch;
  logic [1:0] aluop;
  logic       irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca, halt;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  // op is only trusted in DECODE, so the lw/sw choice is remembered for MEMADR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      is_sw <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) is_sw <= (bus.op == OP_SW);
    end
  end

  always_comb begin
    next_state = state;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    halt       = 1'b0;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'b01;
        pcwrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_RTEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        next_state = S_RTWB;
      end
      S_RTWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halt       = 1'b1;
        next_state = S_HALT;
      end
      default:  next_state = S_RST;
    endcase
  end

  // RST is the only state where alucontrol is forced to 000 rather than the add default
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (bus.funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
    if (state == S_RST) alucontrol = 3'b000;
  end

  assign bus.irwrite    = irwrite;
  assign bus.memwrite   = memwrite;
  assign bus.iord       = iord;
  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.halt       = halt;
  assign bus.state_dbg  = state;

endmodule
